// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//    Conditions the raw north/south vehicle-detector inputs for the adaptive
//    traffic controller. Each channel is synchronized, debounced on a slow
//    sample tick, and its debounced rising edges are counted as arrivals.
//    Arrivals are counted over a fixed observation window. At each window end
//    the per-approach arrival count and congestion flag are published.
//
// Ports
//    clk           system clock
//    reset_n       asynchronous reset, active-low
//    raw_north     raw north detector (asynchronous, 1 = vehicle present)
//    raw_south     raw south detector (asynchronous, 1 = vehicle present)
//    sensor_north  north congested, updated at window end
//    sensor_south  south congested, updated at window end
//    count_north   north arrivals in last completed window (saturating)
//    count_south   south arrivals in last completed window (saturating)
//    window_done   one-clk pulse the cycle after a window closes

module traffic_sensor_cond #(
   parameter int TICK_DIV     = 50_000,
   parameter int DEB_TICKS    = 20,
   parameter int WINDOW_TICKS = 10_000,
   parameter int THRESH       = 4,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             raw_north,
   input  logic             raw_south,
   output logic             sensor_north,
   output logic             sensor_south,
   output logic [CNT_W-1:0] count_north,
   output logic [CNT_W-1:0] count_south,
   output logic             window_done
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int SW = $clog2(DEB_TICKS + 1);
   localparam int WW = $clog2(WINDOW_TICKS + 1);

   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0]    DEB_LAST = SW'(DEB_TICKS - 1);
   localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam int unsigned      THRESH_U = THRESH;

   typedef enum logic {COUNT, CLOSE} state_t;

   // Channel index 0 = north, 1 = south throughout.
   logic [1:0]       raw_vec;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [SW-1:0]    stab [2];
   logic [CNT_W-1:0] run  [2];
   logic [CNT_W-1:0] final_cnt [2];
   logic [1:0]       arrival;
   logic [PW-1:0]    prescale;
   logic             tick;
   logic [WW-1:0]    win_cnt;
   state_t           state;

   assign raw_vec = {raw_south, raw_north};
   assign tick    = (prescale == PRE_LAST);

   // Two-flop synchronizer; only sync2 is used downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_vec;
         sync2 <= sync1;
      end
   end

   // Sample-tick prescaler.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescale <= '0;
      end else if (tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   // The arrival strobe is decoded from the state that is about to flip the
   // debounced level high, so it sits on the tick cycle itself and a rise
   // accepted on the closing tick still belongs to the closing window.
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         arrival[ch]   = tick && sync2[ch] && !deb[ch] && (stab[ch] == DEB_LAST);
         final_cnt[ch] = (arrival[ch] && (run[ch] != CNT_MAX)) ?
                         run[ch] + CNT_W'(1) : run[ch];
      end
   end

   // Debouncer: a changed level must persist for DEB_TICKS consecutive ticks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb <= '0;
         for (int ch = 0; ch < 2; ch++) begin
            stab[ch] <= '0;
         end
      end else if (tick) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (sync2[ch] != deb[ch]) begin
               if (stab[ch] == DEB_LAST) begin
                  deb[ch]  <= sync2[ch];
                  stab[ch] <= '0;
               end else begin
                  stab[ch] <= stab[ch] + SW'(1);
               end
            end else begin
               stab[ch] <= '0;
            end
         end
      end
   end

   // Window FSM: accumulate arrivals in COUNT, publish on the closing tick,
   // and spend one clk in CLOSE to raise window_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= COUNT;
         win_cnt      <= '0;
         run[0]       <= '0;
         run[1]       <= '0;
         count_north  <= '0;
         count_south  <= '0;
         sensor_north <= 1'b0;
         sensor_south <= 1'b0;
         window_done  <= 1'b0;
      end else begin
         window_done <= 1'b0;
         if (state == CLOSE) begin
            state <= COUNT;
         end
         if (tick) begin
            if (win_cnt == WIN_LAST) begin
               state        <= CLOSE;
               window_done  <= 1'b1;
               win_cnt      <= '0;
               run[0]       <= '0;
               run[1]       <= '0;
               count_north  <= final_cnt[0];
               count_south  <= final_cnt[1];
               sensor_north <= (32'(final_cnt[0]) >= THRESH_U);
               sensor_south <= (32'(final_cnt[1]) >= THRESH_U);
            end else begin
               win_cnt <= win_cnt + WW'(1);
               run[0]  <= final_cnt[0];
               run[1]  <= final_cnt[1];
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond
//    Directed bench for traffic_sensor_cond. Two instances share the clock:
//    dut uses a 16-tick window (64 clk), dut_long a 256-tick window
//    (1024 clk) for multi-pulse and saturation scenarios.
//    Both use TICK_DIV=4, DEB_TICKS=3, THRESH=2, CNT_W=4.

module tb_traffic_sensor_cond;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       raw_north;
   logic       raw_south;
   logic       sensor_north;
   logic       sensor_south;
   logic [3:0] count_north;
   logic [3:0] count_south;
   logic       window_done;

   logic       reset_l_n;
   logic       raw_north_l;
   logic       raw_south_l;
   logic       sensor_north_l;
   logic       sensor_south_l;
   logic [3:0] count_north_l;
   logic [3:0] count_south_l;
   logic       window_done_l;

   int vectors = 0;
   int miscompares = 0;
   int n;

   always #5 clk = ~clk;

   traffic_sensor_cond #(
      .TICK_DIV(4), .DEB_TICKS(3), .WINDOW_TICKS(16), .THRESH(2), .CNT_W(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .raw_north(raw_north), .raw_south(raw_south),
      .sensor_north(sensor_north), .sensor_south(sensor_south),
      .count_north(count_north), .count_south(count_south),
      .window_done(window_done)
   );

   traffic_sensor_cond #(
      .TICK_DIV(4), .DEB_TICKS(3), .WINDOW_TICKS(256), .THRESH(2), .CNT_W(4)
   ) dut_long (
      .clk(clk), .reset_n(reset_l_n), .raw_north(raw_north_l), .raw_south(raw_south_l),
      .sensor_north(sensor_north_l), .sensor_south(sensor_south_l),
      .count_north(count_north_l), .count_south(count_south_l),
      .window_done(window_done_l)
   );

   // One comparison point: counts the vector and reports any miscompare.
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Waits for window_done of the selected instance, bounded by limit clks,
   // returning the number of posedges consumed.
   task automatic wait_done(input bit sel, input int limit, output int n_clk);
      logic seen;
      n_clk = 0;
      seen  = 1'b0;
      while (!seen && n_clk < limit) begin
         @(posedge clk);
         #1;
         n_clk++;
         seen = sel ? window_done_l : window_done;
      end
      check_output(sel ? "done_seen_long" : "done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      reset_n     = 1'b0;
      reset_l_n   = 1'b0;
      raw_north   = 1'b0;
      raw_south   = 1'b0;
      raw_north_l = 1'b0;
      raw_south_l = 1'b0;

      // 1. Reset state, then two idle windows of 64 clk each.
      repeat (3) @(negedge clk);
      check_output("rst_sensor_north", 32'(sensor_north), 32'd0);
      check_output("rst_sensor_south", 32'(sensor_south), 32'd0);
      check_output("rst_count_north",  32'(count_north),  32'd0);
      check_output("rst_count_south",  32'(count_south),  32'd0);
      check_output("rst_window_done",  32'(window_done),  32'd0);
      reset_n   = 1'b1;
      reset_l_n = 1'b1;
      wait_done(1'b0, 200, n);
      check_output("idle1_period", 32'(n), 32'd64);
      check_output("idle1_count_north", 32'(count_north), 32'd0);
      check_output("idle1_sensor_north", 32'(sensor_north), 32'd0);
      check_output("idle1_sensor_south", 32'(sensor_south), 32'd0);
      wait_done(1'b0, 200, n);
      check_output("idle2_period", 32'(n), 32'd64);
      check_output("idle2_count_south", 32'(count_south), 32'd0);

      // 3. South glitches of 2 ticks (8 clk) high, 4 times, all rejected.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         raw_south = 1'b1;
         repeat (8) @(negedge clk);
         raw_south = 1'b0;
         repeat (7) @(negedge clk);
      end
      wait_done(1'b0, 200, n);
      check_output("glitch_count_south", 32'(count_south), 32'd0);
      check_output("glitch_sensor_south", 32'(sensor_south), 32'd0);

      // 4. North rise raised at clk 52.5 of the window: accepted on tick
      //    edges 56/60/64, i.e. exactly on the closing tick.
      repeat (52) @(posedge clk);
      @(negedge clk);
      raw_north = 1'b1;
      wait_done(1'b0, 200, n);
      check_output("edge_period_rem", 32'(n), 32'd12);
      check_output("edge_count_north", 32'(count_north), 32'd1);
      check_output("edge_sensor_north", 32'(sensor_north), 32'd0);
      wait_done(1'b0, 200, n);
      check_output("edge_next_count_north", 32'(count_north), 32'd0);
      @(negedge clk);
      raw_north = 1'b0;
      wait_done(1'b0, 200, n);
      check_output("fall_count_north", 32'(count_north), 32'd0);

      // Two north pulses (arrivals near clk 12 and 44) to reach THRESH.
      @(negedge clk);
      raw_north = 1'b1;
      repeat (16) @(negedge clk);
      raw_north = 1'b0;
      repeat (16) @(negedge clk);
      raw_north = 1'b1;
      wait_done(1'b0, 200, n);
      check_output("two_period_rem", 32'(n), 32'd32);
      check_output("two_count_north", 32'(count_north), 32'd2);
      check_output("two_sensor_north", 32'(sensor_north), 32'd1);
      check_output("two_sensor_south", 32'(sensor_south), 32'd0);

      // 6. One arrival in the partial window, then reset mid-window.
      @(negedge clk);
      raw_north = 1'b0;
      repeat (16) @(negedge clk);
      raw_north = 1'b1;
      repeat (24) @(negedge clk);
      reset_n   = 1'b0;
      raw_north = 1'b0;
      #1;
      check_output("midrst_sensor_north", 32'(sensor_north), 32'd0);
      check_output("midrst_count_north",  32'(count_north),  32'd0);
      check_output("midrst_window_done",  32'(window_done),  32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_done(1'b0, 200, n);
      check_output("midrst_period", 32'(n), 32'd64);
      check_output("midrst_next_count_north", 32'(count_north), 32'd0);
      check_output("midrst_next_sensor_north", 32'(sensor_north), 32'd0);

      // 2. Long window: 3 clean north pulses, 5 ticks high / 5 ticks low.
      @(negedge clk);
      reset_l_n = 1'b0;
      @(negedge clk);
      reset_l_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         raw_north_l = 1'b1;
         repeat (20) @(negedge clk);
         raw_north_l = 1'b0;
         repeat (20) @(negedge clk);
      end
      wait_done(1'b1, 2000, n);
      check_output("clean_period_rem", 32'(n), 32'd904);
      check_output("clean_count_north", 32'(count_north_l), 32'd3);
      check_output("clean_sensor_north", 32'(sensor_north_l), 32'd1);
      check_output("clean_count_south", 32'(count_south_l), 32'd0);
      check_output("clean_sensor_south", 32'(sensor_south_l), 32'd0);

      // 5. 20 north arrivals in one long window saturate at 15.
      for (int i = 0; i < 20; i++) begin
         raw_north_l = 1'b1;
         repeat (16) @(negedge clk);
         raw_north_l = 1'b0;
         repeat (16) @(negedge clk);
      end
      wait_done(1'b1, 2000, n);
      check_output("sat_count_north", 32'(count_north_l), 32'd15);
      check_output("sat_sensor_north", 32'(sensor_north_l), 32'd1);
      wait_done(1'b1, 2000, n);
      check_output("sat_next_count_north", 32'(count_north_l), 32'd0);
      check_output("sat_next_sensor_north", 32'(sensor_north_l), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
